// File: rtl/cpu_fetch_pkg.sv
// Shared types and constants for the LEGv8 instruction-fetch stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_fetch_pkg;

    localparam int PC_W        = 64;
    localparam int INSTR_BYTES = 4;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_e;

    // Contents of the IF/ID pipeline register
    typedef struct packed {
        logic            valid;
        logic [31:0]     instr;
        logic [PC_W-1:0] pc;
    } if_id_t;

endpackage

// File: rtl/fetch_pc_next.sv
// Next-PC selection for the fetch stage, plus the out-of-bounds flag for the current PC.
// Latency: purely combinational, 0 cycles.
// Backpressure: stall holds the PC; redirect outranks stall; halt and reset outrank everything.
module fetch_pc_next
    import cpu_fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC   = 64'd0,
    parameter int unsigned     IMEM_BYTES = 1024
) (
    input  logic            reset,
    input  logic            halted,
    input  logic            br_taken,
    input  logic            stall,
    input  logic            bounds_en,
    input  logic [PC_W-1:0] pc,
    input  logic [PC_W-1:0] br_target,
    output logic [PC_W-1:0] pc_next,
    output logic            oob
);

    // Last byte of the word at pc must lie inside the ROM; the sum wraps at 64 bits.
    assign oob = (pc + PC_W'(INSTR_BYTES - 1)) >= PC_W'(IMEM_BYTES);

    // Priority: reset, halted, redirect, bounds fault, stall, sequential increment.
    always_comb begin
        pc_next = pc;
        if (reset) begin
            pc_next = RESET_PC;
        end else if (halted) begin
            pc_next = pc;
        end else if (br_taken) begin
            pc_next = {br_target[PC_W-1:2], 2'b00};
        end else if (bounds_en && oob) begin
            pc_next = pc;
        end else if (stall) begin
            pc_next = pc;
        end else begin
            pc_next = pc + PC_W'(INSTR_BYTES);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// LEGv8 fetch stage: holds the PC, drives the instruction ROM, fills IF/ID; optional bounds fault via FETCH_BOUNDS_CHECK_EN.
// Latency: imem_address = pc with 0 cycles; IF/ID updates 1 cycle after the word is presented.
// Backpressure: stall freezes PC and IF/ID; br_taken redirects and squashes even under stall; HALTED freezes until reset.
module fetch_unit
    import cpu_fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC   = 64'd0,
    parameter int unsigned IMEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    output logic [63:0] imem_address,
    input  logic [31:0] imem_instruction,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [63:0] br_target,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [63:0] if_pc,
    output logic [31:0] fetch_count,
    output logic        fault
);

`ifdef FETCH_BOUNDS_CHECK_EN
    localparam logic BOUNDS_EN = 1'b1;
`else
    localparam logic BOUNDS_EN = 1'b0;
`endif

    fetch_state_e    state, state_next;
    logic [PC_W-1:0] pc, pc_next;
    if_id_t          if_id, if_id_next;
    logic [31:0]     count_q, count_next;
    logic            oob;
    logic            oob_hit;

    fetch_pc_next #(
        .RESET_PC   (RESET_PC),
        .IMEM_BYTES (IMEM_BYTES)
    ) u_pc_next (
        .reset      (reset),
        .halted     (state == HALTED),
        .br_taken   (br_taken),
        .stall      (stall),
        .bounds_en  (BOUNDS_EN),
        .pc         (pc),
        .br_target  (br_target),
        .pc_next    (pc_next),
        .oob        (oob)
    );

    // A bounds hit only matters when the check is built in; with it compiled out this is constant 0.
    assign oob_hit = BOUNDS_EN && oob;

    // State, PC, IF/ID and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= RUN;
            pc      <= RESET_PC;
            if_id   <= '0;
            count_q <= '0;
        end else begin
            state   <= state_next;
            pc      <= pc_next;
            if_id   <= if_id_next;
            count_q <= count_next;
        end
    end

    // Next-state and IF/ID update: redirect squashes, bounds hit halts, stall holds, else latch the ROM word.
    always_comb begin
        state_next = state;
        if_id_next = if_id;
        count_next = count_q;
        case (state)
            RUN: begin
                if (br_taken) begin
                    if_id_next.valid = 1'b0;
                end else if (oob_hit) begin
                    state_next       = HALTED;
                    if_id_next.valid = 1'b0;
                end else if (!stall) begin
                    if_id_next.valid = 1'b1;
                    if_id_next.instr = imem_instruction;
                    if_id_next.pc    = pc;
                    count_next       = count_q + 32'd1;
                end
            end
            HALTED: begin
                if_id_next.valid = 1'b0;
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    assign imem_address = pc;
    assign if_valid     = if_id.valid;
    assign if_instr     = if_id.instr;
    assign if_pc        = if_id.pc;
    assign fetch_count  = count_q;
    assign fault        = BOUNDS_EN && (state == HALTED);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a cycle-level reference model and per-cycle compare.
// Latency: model updates on posedge, outputs compared on negedge.
// Backpressure: stall/br_taken driven from a directed step table.
module tb_fetch_unit;

    localparam logic [63:0] RESET_PC   = 64'd0;
    localparam int unsigned IMEM_BYTES = 1024;
`ifdef FETCH_BOUNDS_CHECK_EN
    localparam bit BCHK = 1'b1;
`else
    localparam bit BCHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] imem_address;
    logic [31:0] imem_instruction;
    logic        stall = 1'b0;
    logic        br_taken = 1'b0;
    logic [63:0] br_target = 64'd0;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [63:0] if_pc;
    logic [31:0] fetch_count;
    logic        fault;

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    fetch_unit #(
        .RESET_PC   (RESET_PC),
        .IMEM_BYTES (IMEM_BYTES)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .imem_address     (imem_address),
        .imem_instruction (imem_instruction),
        .stall            (stall),
        .br_taken         (br_taken),
        .br_target        (br_target),
        .if_valid         (if_valid),
        .if_instr         (if_instr),
        .if_pc            (if_pc),
        .fetch_count      (fetch_count),
        .fault            (fault)
    );

    always #5 clk = ~clk;

    // ROM content: each word encodes its own address so a wrong fetch is visible.
    function automatic logic [31:0] rom_word(input logic [63:0] a);
        return 32'hE000_0000 ^ a[31:0];
    endfunction

    assign imem_instruction = rom_word(imem_address);

    // Reference model state
    logic [63:0] m_pc    = 64'd0;
    logic        m_valid = 1'b0;
    logic [31:0] m_instr = 32'd0;
    logic [63:0] m_ifpc  = 64'd0;
    logic [31:0] m_count = 32'd0;
    bit          m_halt  = 1'b0;

    // Model of the fetch rules, evaluated on every rising edge.
    always @(posedge clk) begin
        if (reset) begin
            m_pc = RESET_PC; m_valid = 0; m_instr = 0; m_ifpc = 0; m_count = 0; m_halt = 0;
        end else if (m_halt) begin
            m_valid = 0;
        end else if (br_taken) begin
            m_pc    = br_target & ~64'd3;
            m_valid = 0;
        end else if (BCHK && (m_pc + 64'd3 >= 64'(IMEM_BYTES))) begin
            m_halt  = 1;
            m_valid = 0;
        end else if (!stall) begin
            m_instr = rom_word(m_pc);
            m_ifpc  = m_pc;
            m_valid = 1;
            m_pc    = m_pc + 64'd4;
            m_count = m_count + 32'd1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            check("m_addr",  imem_address, m_pc);
            check("m_valid", 64'(if_valid), 64'(m_valid));
            check("m_instr", 64'(if_instr), 64'(m_instr));
            check("m_ifpc",  if_pc, m_ifpc);
            check("m_count", 64'(fetch_count), 64'(m_count));
            check("m_fault", 64'(fault), 64'(m_halt));
        end
    end

    task automatic step(input logic rst, input logic stl, input logic br, input logic [63:0] tgt);
        reset = rst; stall = stl; br_taken = br; br_target = tgt;
        @(negedge clk);
    endtask

    initial begin
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        chk_on = 1'b1;
        check("rst_pc", imem_address, 64'd0);
        check("rst_valid", 64'(if_valid), 64'd0);
        check("rst_count", 64'(fetch_count), 64'd0);
        check("rst_fault", 64'(fault), 64'd0);

        // Four straight fetches
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0);
            check("seq_addr", imem_address, 64'(4 * (i + 1)));
            check("seq_ifpc", if_pc, 64'(4 * i));
        end
        check("seq_instr", 64'(if_instr), 64'h0000_0000_E000_000C);
        check("seq_count", 64'(fetch_count), 64'd4);
        check("seq_valid", 64'(if_valid), 64'd1);

        // Reset while stalled with a live IF/ID entry
        step(1, 1, 0, 0);
        check("rst2_pc", imem_address, 64'd0);
        check("rst2_valid", 64'(if_valid), 64'd0);
        check("rst2_count", 64'(fetch_count), 64'd0);

        // Stall at pc=8 for three cycles
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 0);
            check("stall_pc", imem_address, 64'd8);
            check("stall_ifpc", if_pc, 64'd4);
            check("stall_count", 64'(fetch_count), 64'd2);
            check("stall_valid", 64'(if_valid), 64'd1);
        end
        step(0, 0, 0, 0);
        check("rel_ifpc", if_pc, 64'd8);
        check("rel_instr", 64'(if_instr), 64'h0000_0000_E000_0008);

        // Redirect under stall at pc=20, then redirect to the current pc
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        check("pre_br_pc", imem_address, 64'd20);
        step(0, 1, 1, 64'h103);
        check("br_pc", imem_address, 64'h100);
        check("br_valid", 64'(if_valid), 64'd0);
        check("br_ifpc", if_pc, 64'd16);
        check("br_count", 64'(fetch_count), 64'd5);
        step(0, 0, 1, 64'h100);
        check("br2_pc", imem_address, 64'h100);
        check("br2_valid", 64'(if_valid), 64'd0);
        step(0, 0, 0, 0);
        check("post_br_ifpc", if_pc, 64'h100);
        check("post_br_valid", 64'(if_valid), 64'd1);
        check("post_br_count", 64'(fetch_count), 64'd6);

        // Run off the end of the ROM
        step(0, 0, 1, 64'd1020);
        step(0, 0, 0, 0);
        check("last_ifpc", if_pc, 64'd1020);
        check("last_valid", 64'(if_valid), 64'd1);
        check("last_pc", imem_address, 64'd1024);
        step(0, 0, 0, 0);
        step(0, 0, 1, 64'd0);
`ifdef FETCH_BOUNDS_CHECK_EN
        check("oob_pc", imem_address, 64'd1024);
        check("oob_fault", 64'(fault), 64'd1);
        check("oob_valid", 64'(if_valid), 64'd0);
        check("oob_count", 64'(fetch_count), 64'd7);
`else
        check("nochk_pc", imem_address, 64'd0);
        check("nochk_fault", 64'(fault), 64'd0);
        check("nochk_ifpc", if_pc, 64'd1024);
        check("nochk_count", 64'(fetch_count), 64'd8);
`endif
        step(1, 0, 0, 0);
        check("rst3_fault", 64'(fault), 64'd0);
        check("rst3_pc", imem_address, 64'd0);

        // Bounds check still applies while stalled
        step(0, 0, 1, 64'd1024);
        step(0, 1, 0, 0);
        check("stall_oob_pc", imem_address, 64'd1024);
        check("stall_oob_fault", 64'(fault), 64'(BCHK));
        step(1, 0, 0, 0);
        check("rst4_fault", 64'(fault), 64'd0);
        step(0, 0, 0, 0);

        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the pipelined LEGv8 CPU; initiator side of the instruction ROM interface.
- Holds the PC and drives a word-aligned byte address to the combinational instruction memory.
- Captures the returned 32-bit word into the IF/ID pipeline register.
- Handles stall, branch redirect/squash, and an optional out-of-bounds fetch fault.

Parameters:
- RESET_PC, 64'd0, PC value loaded on reset.
- IMEM_BYTES, 1024, instruction memory size in bytes; power of two, >4; used for bounds check.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- imem_address  output  64  byte address to instruction ROM; equals pc combinationally.
- imem_instruction  input  32  instruction word returned combinationally for imem_address.
- stall  input  1  hazard unit hold; freeze PC and IF/ID.
- br_taken  input  1  redirect request from later stage.
- br_target  input  64  redirect byte address; sampled when br_taken=1.
- if_valid  output  1  IF/ID contains a live instruction.
- if_instr  output  32  IF/ID instruction.
- if_pc  output  64  PC of if_instr.
- fetch_count  output  32  number of instructions latched valid into IF/ID since reset.
- fault  output  1  sticky out-of-bounds fetch fault; 0 when feature is compiled out.

Behaviour:
- Reset (synchronous; wins over all other inputs, including mid-stall or mid-fault):
  - pc=RESET_PC, if_valid=0, if_instr=32'h0, if_pc=64'h0, fetch_count=0, fault=0, state=RUN.
- imem_address=pc at all times, with zero cycles of added latency. The instruction for pc is latched at the next posedge, so IF/ID lags pc by 1 cycle.
- States: RUN, HALTED. HALTED is reachable only with FETCH_BOUNDS_CHECK_EN; only reset leaves it.
- RUN, priority highest first:
  - br_taken=1 (regardless of stall):
    - pc<=br_target with bits[1:0] forced to 0.
    - if_valid<=0 (squash the word fetched this cycle).
    - if_instr and if_pc hold; fetch_count holds.
  - stall=1, br_taken=0: pc, if_valid, if_instr, if_pc, fetch_count all hold.
  - Otherwise (normal fetch):
    - if_instr<=imem_instruction, if_pc<=pc, if_valid<=1.
    - pc<=pc+4, wrapping modulo 2^64.
    - fetch_count<=fetch_count+1, wrapping modulo 2^32.
- Back-to-back redirects: each one reloads pc and keeps if_valid=0.
- Redirect to the current pc is legal: that word is squashed, then refetched next cycle.
- HALTED: pc and the IF/ID fields freeze, if_valid=0, fault=1. stall and br_taken are ignored.

Optional Feature:
- Macro FETCH_BOUNDS_CHECK_EN.
- Defined:
  - Each RUN cycle that is not redirected checks whether pc+3 >= IMEM_BYTES (compare at 64-bit width).
  - If so, next state is HALTED: fault<=1, if_valid<=0, pc unchanged, fetch_count unchanged.
  - A stall does not prevent the check.
  - br_taken in the same cycle takes priority: redirect occurs and no fault is raised.
- Undefined:
  - No check; fault is tied to 0; the state register is still present but never leaves RUN.
  - Out-of-range words (X from ROM) are latched as-is with if_valid=1.

Decomposition:
- Package cpu_fetch_pkg:
  - typedef fetch_state_e {RUN, HALTED}.
  - Constants INSTR_BYTES=4 and PC_W=64.
  - Typedef if_id_t struct {valid, instr[31:0], pc[63:0]}.
- Sub-module fetch_pc_next:
  - Combinational next-PC mux (reset / redirect / stall / increment / halt).
  - Also produces the out-of-bounds flag.
  - Keeps the top level as registers plus control.

Test Plan:
- Reset, then 4 unstalled cycles with ROM words W0..W3 → imem_address 0,4,8,12,16; if_pc 0,4,8,12 with if_instr W0..W3 one cycle later; fetch_count=4.
- At pc=8, stall=1 for 3 cycles → pc stays 8; if_instr/if_pc/if_valid hold; fetch_count unchanged; resumes latching the word at 8 after release.
- At pc=20, br_taken=1 with br_target=0x103 → next pc=0x100, if_valid=0 for one cycle; next if_pc=0x100; also covers stall=1 with br_taken=1 (redirect wins).
- Assert reset while stall=1 and if_valid=1 → next cycle pc=RESET_PC, if_valid=0, fetch_count=0, fault=0.
- With FETCH_BOUNDS_CHECK_EN, IMEM_BYTES=1024: branch to 1020, then run → word at 1020 latched valid; pc=1024 triggers fault=1, if_valid=0, pc frozen at 1024 despite br_taken; reset clears it.
- Same sequence without the macro → fault stays 0, pc advances to 1028, if_valid=1 with X instruction.
